// File: rtl/waylookup_update_arbiter_if.sv
// rtl/waylookup_update_arbiter_if.sv - requester buffers and WayLookup update port bundle
interface waylookup_update_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int PADDR_W = 42,
    parameter int SET_W   = 8,
    parameter int WAYS    = 4
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*PADDR_W-1:0] req_blkPaddr;
    logic [NUM_REQ*SET_W-1:0]   req_vSetIdx;
    logic [NUM_REQ*WAYS-1:0]    req_waymask;
    logic [NUM_REQ-1:0]         req_corrupt;

    logic                       io_update_valid;
    logic [PADDR_W-1:0]         io_update_bits_blkPaddr;
    logic [SET_W-1:0]           io_update_bits_vSetIdx;
    logic [WAYS-1:0]            io_update_bits_waymask;
    logic                       io_update_bits_corrupt;

    modport master (
        output req_valid, req_blkPaddr, req_vSetIdx, req_waymask, req_corrupt,
        input  req_ready,
        input  io_update_valid, io_update_bits_blkPaddr, io_update_bits_vSetIdx,
               io_update_bits_waymask, io_update_bits_corrupt
    );

    modport slave (
        input  req_valid, req_blkPaddr, req_vSetIdx, req_waymask, req_corrupt,
        output req_ready,
        output io_update_valid, io_update_bits_blkPaddr, io_update_bits_vSetIdx,
               io_update_bits_waymask, io_update_bits_corrupt
    );
endinterface

// File: rtl/waylookup_update_arbiter.sv
// rtl/waylookup_update_arbiter.sv - round-robin arbiter sharing the WayLookup update port
// Optional perf counters are built when WAYLOOKUP_UPD_ARB_PERF_EN is defined.
module waylookup_update_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PADDR_W = 42,
    parameter int SET_W   = 8,
    parameter int WAYS    = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic io_flush,
    waylookup_update_arbiter_if.slave upd
`ifdef WAYLOOKUP_UPD_ARB_PERF_EN
    ,
    output logic [15:0] perf_conflict_cnt,
    output logic [15:0] perf_flush_drop_cnt
`endif
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PAY_W = PADDR_W + SET_W + WAYS + 1;

    logic [NUM_REQ-1:0] w_pend_valid;
    logic [PAY_W-1:0]   w_pend_pay [NUM_REQ];
    logic [PAY_W-1:0]   w_in_pay   [NUM_REQ];
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_ready;
    logic [NUM_REQ-1:0] w_accept;
    logic [PTR_W-1:0]   w_gidx;
    logic               w_gany;
    logic [PTR_W:0]     w_sum;

    logic [PTR_W-1:0]   r_rr_ptr;
    logic               r_upd_valid;
    logic [PAY_W-1:0]   r_upd_pay;

    // First pending buffer at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_gany  = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
            end
            if (!w_gany && w_pend_valid[w_sum[PTR_W-1:0]]) begin
                w_gany                     = 1'b1;
                w_gidx                     = w_sum[PTR_W-1:0];
                w_grant[w_sum[PTR_W-1:0]]  = 1'b1;
            end
        end
    end

    assign w_ready       = {NUM_REQ{!io_flush && !reset}} & (~w_pend_valid | w_grant);
    assign w_accept      = upd.req_valid & w_ready;
    assign upd.req_ready = w_ready;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        logic             r_pend;
        logic [PAY_W-1:0] r_pay;

        assign w_in_pay[i] = {upd.req_blkPaddr[i*PADDR_W +: PADDR_W],
                              upd.req_vSetIdx[i*SET_W +: SET_W],
                              upd.req_waymask[i*WAYS +: WAYS],
                              upd.req_corrupt[i]};

        // A granted buffer that is refilled in the same cycle stays pending.
        always_ff @(posedge clock) begin
            if (reset) begin
                r_pend <= 1'b0;
                r_pay  <= '0;
            end else if (io_flush) begin
                r_pend <= 1'b0;
            end else if (w_accept[i]) begin
                r_pend <= 1'b1;
                r_pay  <= w_in_pay[i];
            end else if (w_grant[i]) begin
                r_pend <= 1'b0;
            end
        end

        assign w_pend_valid[i] = r_pend;
        assign w_pend_pay[i]   = r_pay;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr    <= '0;
            r_upd_valid <= 1'b0;
            r_upd_pay   <= '0;
        end else begin
            r_upd_valid <= w_gany && !io_flush;
            if (w_gany) begin
                r_upd_pay <= w_pend_pay[w_gidx];
            end
            if (w_gany && !io_flush) begin
                r_rr_ptr <= (w_gidx == PTR_W'(NUM_REQ-1)) ? '0 : w_gidx + PTR_W'(1);
            end
        end
    end

    assign upd.io_update_valid         = r_upd_valid;
    assign upd.io_update_bits_blkPaddr = r_upd_pay[PAY_W-1 -: PADDR_W];
    assign upd.io_update_bits_vSetIdx  = r_upd_pay[WAYS+SET_W : WAYS+1];
    assign upd.io_update_bits_waymask  = r_upd_pay[WAYS:1];
    assign upd.io_update_bits_corrupt  = r_upd_pay[0];

`ifdef WAYLOOKUP_UPD_ARB_PERF_EN
    logic [15:0] r_conflict_cnt;
    logic [15:0] r_flush_drop_cnt;
    logic [3:0]  w_pend_cnt;
    logic [16:0] w_drop_sum;

    assign w_pend_cnt = 4'($countones(w_pend_valid));
    assign w_drop_sum = {1'b0, r_flush_drop_cnt} + 17'(w_pend_cnt);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_conflict_cnt   <= '0;
            r_flush_drop_cnt <= '0;
        end else begin
            if (w_pend_cnt >= 4'd2 && r_conflict_cnt != 16'hFFFF) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
            if (io_flush) begin
                r_flush_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            end
        end
    end

    assign perf_conflict_cnt   = r_conflict_cnt;
    assign perf_flush_drop_cnt = r_flush_drop_cnt;
`endif
endmodule

// File: tb/tb_waylookup_update_arbiter.sv
// tb/tb_waylookup_update_arbiter.sv - scoreboard bench for waylookup_update_arbiter
module tb_waylookup_update_arbiter;
    localparam int N   = 3;
    localparam int PW  = 42;
    localparam int SW  = 8;
    localparam int WW  = 4;
    localparam int PAY = PW + SW + WW + 1;

    logic clock = 1'b0;
    logic reset;
    logic io_flush;

    always #5 clock = ~clock;

    waylookup_update_arbiter_if #(.NUM_REQ(N), .PADDR_W(PW), .SET_W(SW), .WAYS(WW)) bus ();

    waylookup_update_arbiter #(.NUM_REQ(N), .PADDR_W(PW), .SET_W(SW), .WAYS(WW)) dut (
        .clock    (clock),
        .reset    (reset),
        .io_flush (io_flush),
        .upd      (bus.slave)
    );

    typedef struct {
        int             due;
        logic [PAY-1:0] pay;
    } exp_t;

    exp_t           expq[$];
    int             checks = 0;
    int             errors = 0;
    int             cyc    = 0;

    logic [PW-1:0]  d_pa  [N];
    logic [SW-1:0]  d_set [N];
    logic [WW-1:0]  d_way [N];
    logic           d_cor [N];

    logic           m_pend [N];
    logic [PAY-1:0] m_pay  [N];
    int             m_rr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [PAY-1:0] dut_bits();
        return {bus.io_update_bits_blkPaddr, bus.io_update_bits_vSetIdx,
                bus.io_update_bits_waymask, bus.io_update_bits_corrupt};
    endfunction

    task automatic rand_pay();
        for (int i = 0; i < N; i++) begin
            d_pa[i]  = PW'({$urandom, $urandom});
            d_set[i] = SW'($urandom);
            d_way[i] = WW'(1 << $urandom_range(WW-1, 0));
            d_cor[i] = ($urandom_range(3, 0) == 0);
        end
    endtask

    // One clock cycle: drive at the falling edge, predict, then wait for the next falling edge.
    task automatic step(input logic [N-1:0] v, input logic fl, input logic rst);
        int             g;
        logic [N-1:0]   rdy;
        for (int i = 0; i < N; i++) begin
            bus.req_blkPaddr[i*PW +: PW] = d_pa[i];
            bus.req_vSetIdx[i*SW +: SW]  = d_set[i];
            bus.req_waymask[i*WW +: WW]  = d_way[i];
            bus.req_corrupt[i]           = d_cor[i];
        end
        bus.req_valid = v;
        io_flush      = fl;
        reset         = rst;
        cyc++;
        #1;
        g = -1;
        for (int d = 0; d < N; d++) begin
            if (g < 0 && m_pend[(m_rr + d) % N]) g = (m_rr + d) % N;
        end
        for (int i = 0; i < N; i++) rdy[i] = !rst && !fl && (!m_pend[i] || g == i);
        chk("req_ready", 64'(bus.req_ready), 64'(rdy));
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 1'b0;
                m_pay[i]  = '0;
            end
            m_rr = 0;
        end else if (fl) begin
            for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        end else begin
            if (g >= 0) begin
                expq.push_back('{due: cyc, pay: m_pay[g]});
                m_pend[g] = 1'b0;
                m_rr      = (g + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (v[i] && rdy[i]) begin
                    m_pend[i] = 1'b1;
                    m_pay[i]  = {d_pa[i], d_set[i], d_way[i], d_cor[i]};
                end
            end
        end
        @(negedge clock);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            if (bus.io_update_valid === 1'b1) begin
                if (expq.size() == 0) begin
                    chk("unexpected_update", 64'd1, 64'd0);
                end else begin
                    e = expq.pop_front();
                    chk("update_cycle", 64'(cyc), 64'(e.due));
                    chk("update_bits", 64'(dut_bits()), 64'(e.pay));
                end
            end else if (expq.size() > 0 && expq[0].due <= cyc) begin
                e = expq.pop_front();
                chk("missing_update", 64'(bus.io_update_valid), 64'd1);
            end
        end
    end

    initial begin : stimulus
        logic [N-1:0] v;
        int           dens;
        reset         = 1'b1;
        io_flush      = 1'b0;
        bus.req_valid = '0;
        for (int i = 0; i < N; i++) begin
            d_pa[i] = '0; d_set[i] = '0; d_way[i] = '0; d_cor[i] = 1'b0;
            m_pend[i] = 1'b0; m_pay[i] = '0;
        end
        m_rr = 0;
        @(negedge clock);
        @(negedge clock);
        chk("reset_ready", 64'(bus.req_ready), 64'd0);
        chk("reset_valid", 64'(bus.io_update_valid), 64'd0);
        chk("reset_bits", 64'(dut_bits()), 64'd0);

        d_pa[0] = PW'(42'h123); d_set[0] = 8'h05; d_way[0] = 4'b0010; d_cor[0] = 1'b0;
        step(3'b001, 0, 0);
        step(3'b000, 0, 0);
        step(3'b000, 0, 0);

        rand_pay();
        d_pa[1] = d_pa[0]; d_set[1] = d_set[0];
        step(3'b011, 0, 0);
        step(3'b000, 0, 0);
        step(3'b000, 0, 0);

        for (int k = 0; k < 8; k++) begin
            rand_pay();
            step(3'b001, 0, 0);
        end
        step(3'b000, 0, 0);

        for (int k = 0; k < 9; k++) begin
            rand_pay();
            d_cor[0] = 1'b0; d_cor[1] = 1'b0; d_cor[2] = 1'b1;
            step(3'b111, 0, 0);
        end

        rand_pay();
        step(3'b011, 0, 0);
        step(3'b000, 1, 0);
        step(3'b000, 0, 0);
        step(3'b000, 0, 0);

        for (int k = 0; k < 400; k++) begin
            rand_pay();
            dens = $urandom_range(3, 0);
            for (int i = 0; i < N; i++) v[i] = ($urandom_range(3, 0) < dens + 1);
            step(v, ($urandom_range(29, 0) == 0), 0);
        end

        rand_pay();
        step(3'b111, 0, 0);
        step(3'b111, 0, 0);
        step(3'b111, 0, 1);
        chk("midreset_valid", 64'(bus.io_update_valid), 64'd0);
        chk("midreset_bits", 64'(dut_bits()), 64'd0);

        for (int k = 0; k < 200; k++) begin
            rand_pay();
            for (int i = 0; i < N; i++) v[i] = ($urandom_range(1, 0) == 1);
            step(v, ($urandom_range(19, 0) == 0), 0);
        end

        for (int k = 0; k < 6; k++) step(3'b000, 0, 0);
        chk("queue_drained", 64'(expq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
